// File: rtl/snake_core_param.sv
// Parametrised snake-game engine: body shift register, direction latch, growth and collision.
// Optional feature macro: SNAKE_WRAP_EN (playfield wraps at the edges instead of walls).
module snake_core_param #(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 16,
    parameter int COORD_W  = 4,
    parameter int MAX_LEN  = 64,
    parameter int LEN_W    = 7,
    parameter int INIT_LEN = 3
) (
    input  logic                           slw_clk,
    input  logic                           reset,
    input  logic                           step,
    input  logic                           up,
    input  logic                           down,
    input  logic                           left,
    input  logic                           right,
    input  logic [COORD_W-1:0]             food_x,
    input  logic [COORD_W-1:0]             food_y,
    input  logic                           food_valid,
    output logic [MAX_LEN*2*COORD_W-1:0]   snake,
    output logic [LEN_W-1:0]               length,
    output logic [1:0]                     dir,
    output logic                           ate,
    output logic                           game_over,
    output logic                           win
);

    localparam int SEG_W = 2 * COORD_W;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DEAD = 1'b1
    } state_t;

    state_t             state_r;
    logic [SEG_W-1:0]   seg_r [MAX_LEN];
    logic [LEN_W-1:0]   len_r;
    logic [1:0]         dir_r;
    logic [1:0]         pend_dir_r;
    logic               ate_r;
    logic               game_over_r;
    logic               win_r;

    logic [COORD_W-1:0] head_x_s;
    logic [COORD_W-1:0] head_y_s;
    logic [SEG_W-1:0]   nh_s;
    logic               wall_s;
    logic               eat_s;
    logic               self_hit_s;
    logic [LEN_W-1:0]   lim_s;
    logic [1:0]         req_s;
    logic               btn_any_s;
    logic               rev_s;

    assign head_x_s = seg_r[0][COORD_W-1:0];
    assign head_y_s = seg_r[0][SEG_W-1:COORD_W];

`ifdef SNAKE_WRAP_EN
    logic [COORD_W-1:0] nx_s;
    logic [COORD_W-1:0] ny_s;

    // Next head position on a torus: each edge leads to the opposite edge.
    always_comb begin
        nx_s = head_x_s;
        ny_s = head_y_s;
        case (pend_dir_r)
            2'b00:   ny_s = (head_y_s == {COORD_W{1'b0}}) ? COORD_W'(GRID_H - 1) : head_y_s - COORD_W'(1);
            2'b01:   ny_s = (head_y_s == COORD_W'(GRID_H - 1)) ? {COORD_W{1'b0}} : head_y_s + COORD_W'(1);
            2'b10:   nx_s = (head_x_s == {COORD_W{1'b0}}) ? COORD_W'(GRID_W - 1) : head_x_s - COORD_W'(1);
            2'b11:   nx_s = (head_x_s == COORD_W'(GRID_W - 1)) ? {COORD_W{1'b0}} : head_x_s + COORD_W'(1);
            default: nx_s = head_x_s;
        endcase
        nh_s   = {ny_s, nx_s};
        wall_s = 1'b0;
    end
`else
    localparam int CW = COORD_W + 1;
    logic [CW-1:0] nx_s;
    logic [CW-1:0] ny_s;

    // Next head position with one guard bit: both x==GRID_W and 0-1 (all ones) land beyond the wall.
    always_comb begin
        nx_s = {1'b0, head_x_s};
        ny_s = {1'b0, head_y_s};
        case (pend_dir_r)
            2'b00:   ny_s = {1'b0, head_y_s} - CW'(1);
            2'b01:   ny_s = {1'b0, head_y_s} + CW'(1);
            2'b10:   nx_s = {1'b0, head_x_s} - CW'(1);
            2'b11:   nx_s = {1'b0, head_x_s} + CW'(1);
            default: nx_s = {1'b0, head_x_s};
        endcase
        nh_s   = {ny_s[COORD_W-1:0], nx_s[COORD_W-1:0]};
        wall_s = (nx_s >= CW'(GRID_W)) || (ny_s >= CW'(GRID_H));
    end
`endif

    // Food and self-collision; the tail cell only counts as body when it stays put (eating).
    always_comb begin
        eat_s      = food_valid && (nh_s == {food_y, food_x});
        lim_s      = eat_s ? len_r : (len_r - LEN_W'(1));
        self_hit_s = 1'b0;
        for (int k = 1; k < MAX_LEN; k++) begin
            self_hit_s = self_hit_s | ((LEN_W'(k) < lim_s) && (seg_r[k] == nh_s));
        end
    end

    // Button priority up>down>left>right; a request opposite the current heading is dropped.
    always_comb begin
        btn_any_s = up | down | left | right;
        if (up) begin
            req_s = 2'b00;
        end else if (down) begin
            req_s = 2'b01;
        end else if (left) begin
            req_s = 2'b10;
        end else begin
            req_s = 2'b11;
        end
        rev_s = (req_s == (dir_r ^ 2'b01));
    end

    // Game state: reset image, direction latch, step-driven body shift and collision handling.
    always_ff @(posedge slw_clk) begin
        if (reset) begin
            state_r     <= ST_RUN;
            dir_r       <= 2'b11;
            pend_dir_r  <= 2'b11;
            len_r       <= LEN_W'(INIT_LEN);
            ate_r       <= 1'b0;
            game_over_r <= 1'b0;
            win_r       <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_r[i] <= (i < INIT_LEN) ? {{COORD_W{1'b0}}, COORD_W'(INIT_LEN - 1 - i)} : {SEG_W{1'b0}};
            end
        end else begin
            if (btn_any_s && !rev_s) begin
                pend_dir_r <= req_s;
            end
            ate_r <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (step) begin
                        if (wall_s || self_hit_s) begin
                            state_r     <= ST_DEAD;
                            game_over_r <= 1'b1;
                        end else begin
                            dir_r    <= pend_dir_r;
                            seg_r[0] <= nh_s;
                            for (int i = 1; i < MAX_LEN; i++) begin
                                seg_r[i] <= seg_r[i-1];
                            end
                            if (eat_s) begin
                                ate_r <= 1'b1;
                                if (len_r < LEN_W'(MAX_LEN)) begin
                                    len_r <= len_r + LEN_W'(1);
                                    win_r <= ((len_r + LEN_W'(1)) == LEN_W'(MAX_LEN));
                                end
                            end else begin
                                // Vacate the cell the old tail moved into after the shift.
                                for (int i = 1; i < MAX_LEN; i++) begin
                                    if (LEN_W'(i) == len_r) begin
                                        seg_r[i] <= {SEG_W{1'b0}};
                                    end
                                end
                            end
                        end
                    end
                end
                ST_DEAD: begin
                    game_over_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_DEAD;
                    game_over_r <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
        assign snake[g*SEG_W +: SEG_W] = seg_r[g];
    end

    assign length    = len_r;
    assign dir       = dir_r;
    assign ate       = ate_r;
    assign game_over = game_over_r;
    assign win       = win_r;

endmodule

// File: tb/tb_snake_core_param.sv
// Self-checking bench for snake_core_param: vector table plus hand sequences, scoreboard-checked.
module tb_snake_core_param;

    localparam int CW = 4;
    localparam int ML = 64;
    localparam int LW = 7;

    logic               slw_clk = 1'b0;
    logic               reset = 1'b1;
    logic               step = 1'b0;
    logic               up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [CW-1:0]      food_x = '0, food_y = '0;
    logic               food_valid = 1'b0;
    logic [ML*2*CW-1:0] snake;
    logic [LW-1:0]      length;
    logic [1:0]         dir;
    logic               ate, game_over, win;

    snake_core_param #(
        .GRID_W(16), .GRID_H(16), .COORD_W(CW), .MAX_LEN(ML), .LEN_W(LW), .INIT_LEN(3)
    ) dut (
        .slw_clk(slw_clk), .reset(reset), .step(step),
        .up(up), .down(down), .left(left), .right(right),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .snake(snake), .length(length), .dir(dir), .ate(ate),
        .game_over(game_over), .win(win)
    );

    always #5 slw_clk = ~slw_clk;

    localparam logic [3:0] BU = 4'b1000, BD = 4'b0100, BL = 4'b0010, BR = 4'b0001;

    typedef struct {
        string      tag;
        logic [3:0] btn;
        logic       stp;
        logic       fv;
        logic [7:0] food;
        logic [7:0] head;
        int         len;
        logic [1:0] dir;
        logic       ate;
        logic       go;
    } vec_t;

    vec_t tbl [18];
    vec_t sb_q [$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] seg(input int k);
        return snake[k*8 +: 8];
    endfunction

    // Drive one vector for a cycle, then compare against the scoreboard entry on the following negedge.
    task automatic run_vec(input vec_t v, input logic rst);
        vec_t e;
        @(negedge slw_clk);
        reset = rst;
        {up, down, left, right} = v.btn;
        step = v.stp;
        food_valid = v.fv;
        {food_y, food_x} = v.food;
        sb_q.push_back(v);
        @(posedge slw_clk);
        #1;
        reset = 1'b0;
        {up, down, left, right} = 4'b0000;
        step = 1'b0;
        food_valid = 1'b0;
        @(negedge slw_clk);
        e = sb_q.pop_front();
        chk({e.tag, ".head"}, {24'd0, seg(0)}, {24'd0, e.head});
        chk({e.tag, ".len"}, {25'd0, length}, e.len);
        chk({e.tag, ".dir"}, {30'd0, dir}, {30'd0, e.dir});
        chk({e.tag, ".ate"}, {31'd0, ate}, {31'd0, e.ate});
        chk({e.tag, ".go"}, {31'd0, game_over}, {31'd0, e.go});
    endtask

    task automatic cyc(input string tag, input logic [3:0] btn, input logic stp, input logic fv,
                       input logic [7:0] food, input logic [7:0] head, input int len,
                       input logic [1:0] d, input logic a, input logic go, input logic rst);
        vec_t v;
        v = '{tag, btn, stp, fv, food, head, len, d, a, go};
        run_vec(v, rst);
    endtask

    initial begin
        tbl[0]  = '{"t1s1",  4'b0,       1'b1, 1'b0, 8'h00, 8'h03, 3, 2'b11, 1'b0, 1'b0};
        tbl[1]  = '{"t1s2",  4'b0,       1'b1, 1'b0, 8'h00, 8'h04, 3, 2'b11, 1'b0, 1'b0};
        tbl[2]  = '{"t1s3",  4'b0,       1'b1, 1'b0, 8'h00, 8'h05, 3, 2'b11, 1'b0, 1'b0};
        tbl[3]  = '{"t2bl",  BL,         1'b0, 1'b0, 8'h00, 8'h05, 3, 2'b11, 1'b0, 1'b0};
        tbl[4]  = '{"t2rev", 4'b0,       1'b1, 1'b0, 8'h00, 8'h06, 3, 2'b11, 1'b0, 1'b0};
        tbl[5]  = '{"t2bd",  BD | BL,    1'b0, 1'b0, 8'h00, 8'h06, 3, 2'b11, 1'b0, 1'b0};
        tbl[6]  = '{"t2dn",  4'b0,       1'b1, 1'b0, 8'h00, 8'h16, 3, 2'b01, 1'b0, 1'b0};
        tbl[7]  = '{"t3eat", 4'b0,       1'b1, 1'b1, 8'h26, 8'h26, 4, 2'b01, 1'b1, 1'b0};
        tbl[8]  = '{"bul",   BU | BL,    1'b0, 1'b0, 8'h00, 8'h26, 4, 2'b01, 1'b0, 1'b0};
        tbl[9]  = '{"revup", 4'b0,       1'b1, 1'b1, 8'h55, 8'h36, 4, 2'b01, 1'b0, 1'b0};
        tbl[10] = '{"grow5", 4'b0,       1'b1, 1'b1, 8'h46, 8'h46, 5, 2'b01, 1'b1, 1'b0};
        tbl[11] = '{"br",    BR,         1'b0, 1'b0, 8'h00, 8'h46, 5, 2'b01, 1'b0, 1'b0};
        tbl[12] = '{"sr",    4'b0,       1'b1, 1'b0, 8'h00, 8'h47, 5, 2'b11, 1'b0, 1'b0};
        tbl[13] = '{"bprio", BU|BD|BL,   1'b0, 1'b0, 8'h00, 8'h47, 5, 2'b11, 1'b0, 1'b0};
        tbl[14] = '{"su",    4'b0,       1'b1, 1'b0, 8'h00, 8'h37, 5, 2'b00, 1'b0, 1'b0};
        tbl[15] = '{"bl2",   BL,         1'b0, 1'b0, 8'h00, 8'h37, 5, 2'b00, 1'b0, 1'b0};
        tbl[16] = '{"selfh", 4'b0,       1'b1, 1'b0, 8'h00, 8'h37, 5, 2'b00, 1'b0, 1'b1};
        tbl[17] = '{"dead",  4'b0,       1'b1, 1'b0, 8'h00, 8'h37, 5, 2'b00, 1'b0, 1'b1};

        // Reset image
        cyc("rst", 4'b0, 1'b0, 1'b0, 8'h00, 8'h02, 3, 2'b11, 1'b0, 1'b0, 1'b1);
        chk("rst.seg1", {24'd0, seg(1)}, 32'h01);
        chk("rst.seg2", {24'd0, seg(2)}, 32'h00);
        chk("rst.seg3", {24'd0, seg(3)}, 32'h00);
        chk("rst.win", {31'd0, win}, 32'd0);

        foreach (tbl[i]) begin
            run_vec(tbl[i], 1'b0);
            if (i == 2) begin
                chk("t1.seg1", {24'd0, seg(1)}, 32'h04);
                chk("t1.seg2", {24'd0, seg(2)}, 32'h03);
                chk("t1.seg3", {24'd0, seg(3)}, 32'h00);
            end
        end
        chk("t6.seg1", {24'd0, seg(1)}, 32'h47);
        chk("t6.seg4", {24'd0, seg(4)}, 32'h26);
        chk("t6.seg5", {24'd0, seg(5)}, 32'h00);
        chk("t6.win", {31'd0, win}, 32'd0);

        // Reset coinciding with a step restores the initial image and ignores the step
        cyc("rststep", 4'b0, 1'b1, 1'b0, 8'h00, 8'h02, 3, 2'b11, 1'b0, 1'b0, 1'b1);
        chk("rststep.seg1", {24'd0, seg(1)}, 32'h01);
        cyc("rstrun", 4'b0, 1'b1, 1'b0, 8'h00, 8'h03, 3, 2'b11, 1'b0, 1'b0, 1'b0);

        // Moving into the vacating tail cell is legal
        cyc("rstB", 4'b0, 1'b0, 1'b0, 8'h00, 8'h02, 3, 2'b11, 1'b0, 1'b0, 1'b1);
        cyc("tEat", 4'b0, 1'b1, 1'b1, 8'h03, 8'h03, 4, 2'b11, 1'b1, 1'b0, 1'b0);
        chk("tEat.tail", {24'd0, seg(3)}, 32'h00);
        chk("tEat.seg2", {24'd0, seg(2)}, 32'h01);
        cyc("tbD", BD, 1'b0, 1'b0, 8'h00, 8'h03, 4, 2'b11, 1'b0, 1'b0, 1'b0);
        cyc("tD", 4'b0, 1'b1, 1'b0, 8'h00, 8'h13, 4, 2'b01, 1'b0, 1'b0, 1'b0);
        cyc("tbL", BL, 1'b0, 1'b0, 8'h00, 8'h13, 4, 2'b01, 1'b0, 1'b0, 1'b0);
        cyc("tL", 4'b0, 1'b1, 1'b0, 8'h00, 8'h12, 4, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc("tbU", BU, 1'b0, 1'b0, 8'h00, 8'h12, 4, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc("tU", 4'b0, 1'b1, 1'b0, 8'h00, 8'h02, 4, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("tU.seg3", {24'd0, seg(3)}, 32'h03);

        // Right edge: 13 steps reach x=15, the 14th crosses the edge
        cyc("rstC", 4'b0, 1'b0, 1'b0, 8'h00, 8'h02, 3, 2'b11, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 13; i++) begin
            cyc("wallrun", 4'b0, 1'b1, 1'b0, 8'h00, 8'(2 + i), 3, 2'b11, 1'b0, 1'b0, 1'b0);
        end
`ifdef SNAKE_WRAP_EN
        cyc("wrapx", 4'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3, 2'b11, 1'b0, 1'b0, 1'b0);
        chk("wrapx.seg1", {24'd0, seg(1)}, 32'h0F);
        cyc("wrapx2", 4'b0, 1'b1, 1'b0, 8'h00, 8'h01, 3, 2'b11, 1'b0, 1'b0, 1'b0);
`else
        cyc("wallx", 4'b0, 1'b1, 1'b0, 8'h00, 8'h0F, 3, 2'b11, 1'b0, 1'b1, 1'b0);
        chk("wallx.seg1", {24'd0, seg(1)}, 32'h0E);
        cyc("wallx2", 4'b0, 1'b1, 1'b0, 8'h00, 8'h0F, 3, 2'b11, 1'b0, 1'b1, 1'b0);
`endif

        // Top edge: up from row 0 underflows
        cyc("rstD", 4'b0, 1'b0, 1'b0, 8'h00, 8'h02, 3, 2'b11, 1'b0, 1'b0, 1'b1);
        cyc("dbU", BU, 1'b0, 1'b0, 8'h00, 8'h02, 3, 2'b11, 1'b0, 1'b0, 1'b0);
`ifdef SNAKE_WRAP_EN
        cyc("wrapy", 4'b0, 1'b1, 1'b0, 8'h00, 8'hF2, 3, 2'b00, 1'b0, 1'b0, 1'b0);
`else
        cyc("wally", 4'b0, 1'b1, 1'b0, 8'h00, 8'h02, 3, 2'b11, 1'b0, 1'b1, 1'b0);
`endif

        chk("sb.empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
